// File: rtl/enviar_pkg.sv
// Shared types for the enviar_planificador frame scheduler.
// ENVIAR_CHECKSUM_EN adds the CHK state (trailing XOR byte per frame).
package enviar_pkg;

  localparam logic [3:0] HDR_TAG_DEF = 4'hA;

`ifdef ENVIAR_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, FETCH, SEND, WAIT_HI, WAIT_LO, CHK} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, FETCH, SEND, WAIT_HI, WAIT_LO} state_t;
`endif

  // Round-robin successor, wrapping n-1 -> 0.
  function automatic int next_rr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/enviar_planificador_if.sv
// Requester streams, transmitter handshake and status of the frame scheduler.
interface enviar_planificador_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0][7:0]  src_data;
  logic [NUM_REQ-1:0]       src_valid;
  logic [NUM_REQ-1:0]       src_last;
  logic [NUM_REQ-1:0]       src_ready;
  logic [NUM_REQ-1:0]       gnt;
  logic                     start;
  logic [7:0]               datos;
  logic                     bussy_e;
  logic                     frame_busy;
  logic                     err_timeout;

  modport master (
    input  req, src_data, src_valid, src_last, bussy_e,
    output src_ready, gnt, start, datos, frame_busy, err_timeout
  );

  modport slave (
    output req, src_data, src_valid, src_last, bussy_e,
    input  src_ready, gnt, start, datos, frame_busy, err_timeout
  );
endinterface

// File: rtl/enviar_rr_arbitro.sv
// Round-robin pick of the first set req at or after the pointer, plus pointer update.
module enviar_rr_arbitro
  import enviar_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [IW-1:0]      pick,
  output logic               any
);
  localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);

  logic [IW-1:0] ptr;
  logic [IW:0]   sum;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    sum  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= NR) sum = sum - NR;
      if (!any && req[sum[IW-1:0]]) begin
        any  = 1'b1;
        pick = sum[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ptr <= '0;
    else if (advance) ptr <= IW'(next_rr(int'(pick), NUM_REQ));
  end

endmodule

// File: rtl/enviar_planificador.sv
// Round-robin frame scheduler sharing one EnviarDatos transmitter among NUM_REQ streams.
// Define ENVIAR_CHECKSUM_EN to append an XOR checksum byte to every frame.
module enviar_planificador
  import enviar_pkg::*;
#(
  parameter int         NUM_REQ      = 4,
  parameter int         BUSY_TIMEOUT = 64,
  parameter logic [3:0] HDR_TAG      = HDR_TAG_DEF
) (
  input logic                   clk,
  input logic                   rst,
  enviar_planificador_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(BUSY_TIMEOUT - 1);

  state_t             state;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gidx, pick;
  logic               any, advance, last_flag;
  logic               start, frame_busy, err_timeout;
  logic [7:0]         datos, hdr;
  logic [CW-1:0]      cnt;
`ifdef ENVIAR_CHECKSUM_EN
  logic [7:0]         csum;
  logic               chk_sent;
`endif

  // New frames are only considered once the transmitter is idle.
  assign advance = (state == IDLE) && any && !bus.bussy_e;
  assign hdr     = {HDR_TAG, 4'(gidx)};

  enviar_rr_arbitro #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req),
    .advance (advance),
    .pick    (pick),
    .any     (any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      gnt         <= '0;
      gidx        <= '0;
      frame_busy  <= 1'b0;
      err_timeout <= 1'b0;
      start       <= 1'b0;
      datos       <= '0;
      last_flag   <= 1'b0;
      cnt         <= '0;
`ifdef ENVIAR_CHECKSUM_EN
      csum        <= '0;
      chk_sent    <= 1'b0;
`endif
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: if (advance) begin
          gnt        <= NUM_REQ'(1) << pick;
          gidx       <= pick;
          frame_busy <= 1'b1;
`ifdef ENVIAR_CHECKSUM_EN
          chk_sent   <= 1'b0;
`endif
          state      <= HDR;
        end
        HDR: begin
          datos     <= hdr;
          last_flag <= 1'b0;
`ifdef ENVIAR_CHECKSUM_EN
          csum      <= hdr;
`endif
          state     <= SEND;
        end
        FETCH: if (bus.src_valid[gidx]) begin
          datos     <= bus.src_data[gidx];
          last_flag <= bus.src_last[gidx];
`ifdef ENVIAR_CHECKSUM_EN
          csum      <= csum ^ bus.src_data[gidx];
`endif
          state     <= SEND;
        end
        SEND: begin
          start <= 1'b1;
          cnt   <= '0;
          state <= WAIT_HI;
        end
        // Transmitter never acknowledging the byte aborts the frame.
        WAIT_HI: begin
          if (bus.bussy_e) state <= WAIT_LO;
          else if (cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            gnt         <= '0;
            frame_busy  <= 1'b0;
            state       <= IDLE;
          end else if (cnt != '1) cnt <= cnt + 1'b1;
        end
        WAIT_LO: if (!bus.bussy_e) begin
          if (!last_flag) state <= FETCH;
`ifdef ENVIAR_CHECKSUM_EN
          else if (!chk_sent) state <= CHK;
`endif
          else begin
            gnt        <= '0;
            frame_busy <= 1'b0;
            state      <= IDLE;
          end
        end
`ifdef ENVIAR_CHECKSUM_EN
        CHK: begin
          datos     <= csum;
          last_flag <= 1'b1;
          chk_sent  <= 1'b1;
          state     <= SEND;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake completes in the same cycle src_valid is seen.
  assign bus.src_ready   = (state == FETCH) ? (gnt & bus.src_valid) : '0;
  assign bus.gnt         = gnt;
  assign bus.start       = start;
  assign bus.datos       = datos;
  assign bus.frame_busy  = frame_busy;
  assign bus.err_timeout = err_timeout;

endmodule
